// File: rtl/gray_window_3x3.sv
// -----------------------------------------------------------------------------
// gray_window_3x3
//
// Purpose:
//   Builds a 3x3 neighbourhood of grayscale pixels from a raster pixel stream
//   for the Sobel edge stage. Two full lines are held in line RAM; the window
//   is a packed 9-pixel vector plus a valid strobe that is raised only when
//   the whole neighbourhood lies inside the current frame.
//
// Parameters:
//   COLS    pixels per line (column counter width = $clog2(COLS))
//   PIX_W   bits per grayscale pixel (window width = 9*PIX_W)
//
// Ports:
//   i_clock        system clock, all logic on the rising edge
//   i_reset        synchronous, active-high reset
//   i_frame_start  restarts row/column counters (alone or with a pixel)
//   i_pix_in       grayscale pixel, raster order
//   i_pix_valid    i_pix_in accepted this cycle (no backpressure)
//   o_window       {r-2 row: c-2,c-1,c | r-1 row: c-2,c-1,c | r row: c-2,c-1,c}
//                  top-left pixel in the MSBs, newest pixel (r,c) in the LSBs
//   o_win_valid    one-cycle pulse: o_window is a full interior neighbourhood
//   o_center_col   column of the window centre (c-1)
//
// Configuration macro:
//   GW3_OUT_PIPE_EN  when defined, adds one more output register stage
//                    (latency N+2 instead of N+1); the extra stage resets to 0.
// -----------------------------------------------------------------------------
module gray_window_3x3 #(
  parameter int COLS  = 640,
  parameter int PIX_W = 8
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_frame_start,
  input  logic [PIX_W-1:0]        i_pix_in,
  input  logic                    i_pix_valid,
  output logic [9*PIX_W-1:0]      o_window,
  output logic                    o_win_valid,
  output logic [$clog2(COLS)-1:0] o_center_col
);

  localparam int COL_W = $clog2(COLS);
  localparam int WIN_W = 9 * PIX_W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  // Line RAM: r_lb0 holds the previous line, r_lb1 the line before that.
  // Contents are deliberately not cleared by reset.
  logic [PIX_W-1:0] r_lb0 [COLS];
  logic [PIX_W-1:0] r_lb1 [COLS];

  // Position counters of the next pixel to be accepted.
  logic [COL_W-1:0] r_col;
  logic [1:0]       r_row;

  // First output stage.
  logic [WIN_W-1:0] r_win_s1;
  logic             r_valid_s1;
  logic [COL_W-1:0] r_cc_s1;

  // Effective counters (frame_start clears them before the pixel is placed).
  logic [COL_W-1:0] w_col_eff;
  logic [1:0]       w_row_eff;
  logic [COL_W-1:0] w_col_nxt;
  logic [1:0]       w_row_nxt;

  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;
  logic [WIN_W-1:0] w_win_nxt;
  logic [COL_W-1:0] w_cc_nxt;
  logic             w_hit;

  // Apply frame_start ahead of the accept so a coincident pixel lands at row 0, col 0.
  always_comb begin
    w_col_eff = r_col;
    w_row_eff = r_row;
    if (i_frame_start) begin
      w_col_eff = '0;
      w_row_eff = 2'd0;
    end else begin
      w_col_eff = r_col;
      w_row_eff = r_row;
    end
  end

  // Next column/row: wrap at end of line, row count saturates at 2.
  always_comb begin
    w_col_nxt = w_col_eff;
    w_row_nxt = w_row_eff;
    if (i_pix_valid) begin
      if (w_col_eff == COL_LAST) begin
        w_col_nxt = '0;
        if (w_row_eff == 2'd2) begin
          w_row_nxt = 2'd2;
        end else begin
          w_row_nxt = w_row_eff + 2'd1;
        end
      end else begin
        w_col_nxt = w_col_eff + COL_W'(1);
        w_row_nxt = w_row_eff;
      end
    end else begin
      w_col_nxt = w_col_eff;
      w_row_nxt = w_row_eff;
    end
  end

  // Asynchronous read gives the old contents in the same cycle as the write.
  assign w_lb0_rd = r_lb0[w_col_eff];
  assign w_lb1_rd = r_lb1[w_col_eff];

  // Each row keeps its two newest pixels and appends the new right column.
  assign w_win_nxt = {r_win_s1[8*PIX_W-1:6*PIX_W], w_lb1_rd,
                      r_win_s1[5*PIX_W-1:3*PIX_W], w_lb0_rd,
                      r_win_s1[2*PIX_W-1:0],       i_pix_in};

  // Centre is one column left of the newest pixel (wraps harmlessly at col 0).
  assign w_cc_nxt = w_col_eff - COL_W'(1);

  // Window is interior once two full lines are stored and two columns seen.
  assign w_hit = i_pix_valid && (w_row_eff == 2'd2) && (w_col_eff >= COL_W'(2));

  // Line RAM update: shift the column's old line down and store the new pixel.
  always_ff @(posedge i_clock) begin
    if (!i_reset && i_pix_valid) begin
      r_lb1[w_col_eff] <= w_lb0_rd;
      r_lb0[w_col_eff] <= i_pix_in;
    end
  end

  // Counters and first output stage; window/centre hold on non-accept cycles.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_col      <= '0;
      r_row      <= 2'd0;
      r_win_s1   <= '0;
      r_valid_s1 <= 1'b0;
      r_cc_s1    <= '0;
    end else begin
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      r_valid_s1 <= w_hit;
      if (i_pix_valid) begin
        r_win_s1 <= w_win_nxt;
        r_cc_s1  <= w_cc_nxt;
      end
    end
  end

`ifdef GW3_OUT_PIPE_EN
  logic [WIN_W-1:0] r_win_s2;
  logic             r_valid_s2;
  logic [COL_W-1:0] r_cc_s2;

  // Extra output register stage for timing closure towards the Sobel stage.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_win_s2   <= '0;
      r_valid_s2 <= 1'b0;
      r_cc_s2    <= '0;
    end else begin
      r_win_s2   <= r_win_s1;
      r_valid_s2 <= r_valid_s1;
      r_cc_s2    <= r_cc_s1;
    end
  end

  assign o_window     = r_win_s2;
  assign o_win_valid  = r_valid_s2;
  assign o_center_col = r_cc_s2;
`else
  assign o_window     = r_win_s1;
  assign o_win_valid  = r_valid_s1;
  assign o_center_col = r_cc_s1;
`endif

endmodule

// File: tb/tb_gray_window_3x3.sv
// Self-checking bench for gray_window_3x3 (COLS=4, PIX_W=8).
// Reference model: the frame is kept as an image indexed by absolute row;
// each interior window is read straight from that image.
module tb_gray_window_3x3;

  localparam int COLS  = 4;
  localparam int PIX_W = 8;
  localparam int CW    = $clog2(COLS);

  logic            clk;
  logic            i_reset;
  logic            i_frame_start;
  logic [7:0]      i_pix_in;
  logic            i_pix_valid;
  logic [71:0]     o_window;
  logic            o_win_valid;
  logic [CW-1:0]   o_center_col;

  gray_window_3x3 #(.COLS(COLS), .PIX_W(PIX_W)) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_frame_start(i_frame_start),
    .i_pix_in     (i_pix_in),
    .i_pix_valid  (i_pix_valid),
    .o_window     (o_window),
    .o_win_valid  (o_win_valid),
    .o_center_col (o_center_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic          known;
    logic [71:0]   w;
    logic [CW-1:0] cc;
  } exp_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [7:0]    img [3][COLS];
  int            m_col = 0;
  int            m_row = 0;
  exp_t          e_s1;
  exp_t          e_out;
  logic [71:0]   capq [$];

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w[(8 - (rr * 3 + cc)) * 8 +: 8] = img[(r - 2 + rr) % 3][c - 2 + cc];
    return w;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e = '0;
    e.known = 1'b1;
    return e;
  endfunction

  // One clock: apply inputs, advance the model, compare outputs.
  task automatic step(input logic rst, input logic fs, input logic pv, input logic [7:0] px);
    exp_t prev;
    i_reset = rst; i_frame_start = fs; i_pix_valid = pv; i_pix_in = px;
    @(posedge clk);
    #1;
    prev = e_s1;
    if (rst) begin
      m_col = 0; m_row = 0;
      e_s1 = zero_exp();
      prev = zero_exp();
    end else begin
      if (fs) begin
        m_col = 0; m_row = 0;
      end
      e_s1.v = 1'b0;
      if (pv) begin
        img[m_row % 3][m_col] = px;
        e_s1.cc = CW'((m_col + COLS - 1) % COLS);
        if (m_row >= 2 && m_col >= 2) begin
          e_s1.v = 1'b1;
          e_s1.known = 1'b1;
          e_s1.w = pack_win(m_row, m_col);
        end else begin
          e_s1.known = 1'b0;
        end
        if (m_col == COLS - 1) begin
          m_col = 0; m_row++;
        end else begin
          m_col++;
        end
      end
    end
`ifdef GW3_OUT_PIPE_EN
    e_out = prev;
`else
    e_out = e_s1;
`endif
    check_val("win_valid", {71'd0, o_win_valid}, {71'd0, e_out.v});
    check_val("center_col", {{(72-CW){1'b0}}, o_center_col}, {{(72-CW){1'b0}}, e_out.cc});
    if (e_out.known) check_val("window", o_window, e_out.w);
    if (o_win_valid === 1'b1) capq.push_back(o_window);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    e_s1 = zero_exp();
    e_out = zero_exp();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < COLS; c++) img[r][c] = 8'd0;
    i_reset = 1'b1; i_frame_start = 1'b0; i_pix_valid = 1'b0; i_pix_in = 8'd0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 8'd0);
    check_val("rst_window", o_window, 72'd0);
    step(1'b0, 1'b0, 1'b0, 8'd0);
    check_val("rst_window2", o_window, 72'd0);

    // Test 1: continuous 1..12
    capq.delete();
    for (int p = 1; p <= 12; p++) step(1'b0, 1'b0, 1'b1, 8'(p));
    idle(2);
    check_val("t1_count", 72'(capq.size()), 72'd2);
    if (capq.size() >= 2) begin
      check_val("t1_win0", capq[0], 72'h01_02_03_05_06_07_09_0a_0b);
      check_val("t1_win1", capq[1], 72'h02_03_04_06_07_08_0a_0b_0c);
    end

    // Test 2: same stream with gaps
    step(1'b1, 1'b0, 1'b0, 8'd0);
    capq.delete();
    for (int p = 1; p <= 12; p++) begin
      step(1'b0, 1'b0, 1'b1, 8'(p));
      step(1'b0, 1'b0, 1'b0, 8'd0);
    end
    idle(2);
    check_val("t2_count", 72'(capq.size()), 72'd2);
    if (capq.size() >= 2) begin
      check_val("t2_win0", capq[0], 72'h01_02_03_05_06_07_09_0a_0b);
      check_val("t2_win1", capq[1], 72'h02_03_04_06_07_08_0a_0b_0c);
    end

    // Test 3: partial frame, frame_start alone, new frame 101..112
    for (int p = 1; p <= 10; p++) step(1'b0, 1'b0, 1'b1, 8'(p + 20));
    step(1'b0, 1'b1, 1'b0, 8'd0);
    capq.delete();
    for (int p = 101; p <= 112; p++) step(1'b0, 1'b0, 1'b1, 8'(p));
    idle(2);
    check_val("t3_count", 72'(capq.size()), 72'd2);
    if (capq.size() >= 1) check_val("t3_win0", capq[0], 72'h65_66_67_69_6a_6b_6d_6e_6f);

    // Test 4: frame_start together with first pixel
    for (int p = 1; p <= 5; p++) step(1'b0, 1'b0, 1'b1, 8'(p + 40));
    capq.delete();
    step(1'b0, 1'b1, 1'b1, 8'd201);
    for (int p = 202; p <= 212; p++) step(1'b0, 1'b0, 1'b1, 8'(p));
    idle(2);
    check_val("t4_count", 72'(capq.size()), 72'd2);
    if (capq.size() >= 1) check_val("t4_win0", capq[0], 72'hc9_ca_cb_cd_ce_cf_d1_d2_d3);

    // Test 5: reset during row 2 col 3, then a full new frame is required
    for (int p = 1; p <= 11; p++) step(1'b0, 1'b0, 1'b1, 8'(p + 60));
    step(1'b1, 1'b1, 1'b1, 8'd72);
    check_val("t5_window", o_window, 72'd0);
    capq.delete();
    for (int p = 1; p <= 10; p++) step(1'b0, 1'b0, 1'b1, 8'(p + 80));
    idle(2);
    check_val("t5_count", 72'(capq.size()), 72'd0);

    // Randomized traffic against the image model
    for (int i = 0; i < 3000; i++) begin
      logic rst, fs, pv;
      rst = ($urandom_range(0, 199) == 0);
      fs  = ($urandom_range(0, 49) == 0);
      pv  = ($urandom_range(0, 9) < 7);
      step(rst, fs, pv, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
